fadd_issue_arbiter: RTL and testbench

- Shares one pipelined single-precision adder (align, calc, normalize stages) between two requesters.
- Arbitrates the requesters round-robin and drives the adder operand inputs and pipeline advance enable.
- Tracks which requester owns each in-flight operation and routes each result back to its owner with valid/ready handshakes.
- Stalls the whole adder pipeline when the result at its head is not accepted.

---
 rtl/fadd_issue_arbiter.sv | 125 ++++++++++++
 tb/tb_fadd_issue_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_issue_arbiter.sv
// Two-requester round-robin issue arbiter in front of a shared pipelined FP adder.
// Tracks ownership of every in-flight adder op and returns each result to its owner.
// A result that is not accepted at the pipeline head stalls the whole adder.
module fadd_issue_arbiter #(
    parameter int unsigned LAT = 3
) (
    input  logic        clk,
    input  logic        clrn,
    // Requester 0
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    // Requester 1
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    // Shared adder
    output logic [31:0] fadd_a,
    output logic [31:0] fadd_b,
    output logic        fadd_sub,
    output logic        fadd_en,
    input  logic [31:0] fadd_s,
    // Results
    output logic [31:0] res_s,
    output logic        res0_valid,
    input  logic        res0_ready,
    output logic        res1_valid,
    input  logic        res1_ready,
    output logic [3:0]  inflight
);

    // Per-stage valid and owner tag; index 0 is entry, LAT-1 is the head.
    logic [LAT-1:0] v_q, v_d;
    logic [LAT-1:0] t_q, t_d;
    logic           prio_q, prio_d;
    logic [3:0]     inflight_q, inflight_d;

    logic head_v;
    logic head_t;
    logic stall;
    logic grant;
    logic issue;

    // Head result routing and stall when the owning requester holds off.
    always_comb begin
        head_v     = v_q[LAT-1];
        head_t     = t_q[LAT-1];
        res_s      = fadd_s;
        res0_valid = head_v & ~head_t;
        res1_valid = head_v & head_t;
        stall      = head_v & ~(head_t ? res1_ready : res0_ready);
        fadd_en    = ~stall;
        inflight   = inflight_q;
    end

    // Round-robin grant, issue handshake and operand mux.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = prio_q;
        end else begin
            grant = req1_valid;
        end
        // Readies are forced low during reset even though requester valids may be high.
        req0_ready = clrn & ~stall & req0_valid & ~grant;
        req1_ready = clrn & ~stall & req1_valid & grant;
        issue      = req0_ready | req1_ready;

        fadd_a   = 32'd0;
        fadd_b   = 32'd0;
        fadd_sub = 1'b0;
        if (req0_valid || req1_valid) begin
            if (grant) begin
                fadd_a   = req1_a;
                fadd_b   = req1_b;
                fadd_sub = req1_sub;
            end else begin
                fadd_a   = req0_a;
                fadd_b   = req0_b;
                fadd_sub = req0_sub;
            end
        end
    end

    // Shift valid/tag toward the head on enabled cycles; hold everything on a stall.
    always_comb begin
        v_d    = v_q;
        t_d    = t_q;
        prio_d = prio_q;
        if (fadd_en) begin
            v_d[0] = issue;
            t_d[0] = grant;
            for (int unsigned i = 1; i < LAT; i++) begin
                v_d[i] = v_q[i-1];
                t_d[i] = t_q[i-1];
            end
            if (issue) begin
                prio_d = ~grant;
            end
        end
        inflight_d = 4'd0;
        for (int unsigned i = 0; i < LAT; i++) begin
            inflight_d = inflight_d + 4'(v_d[i]);
        end
    end

    // State registers; reset discards all in-flight ops and prefers port 0.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            v_q        <= '0;
            t_q        <= '0;
            prio_q     <= 1'b0;
            inflight_q <= 4'd0;
        end else begin
            v_q        <= v_d;
            t_q        <= t_d;
            prio_q     <= prio_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_fadd_issue_arbiter.sv
// Scoreboard bench for fadd_issue_arbiter with a behavioural adder stub.
module tb_fadd_issue_arbiter;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        clrn;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic [31:0] fadd_a, fadd_b, fadd_s, res_s;
    logic        fadd_sub, fadd_en;
    logic        res0_valid, res0_ready, res1_valid, res1_ready;
    logic [3:0]  inflight;

    always #5 clk = ~clk;

    fadd_issue_arbiter #(.LAT(LAT)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .fadd_a     (fadd_a),
        .fadd_b     (fadd_b),
        .fadd_sub   (fadd_sub),
        .fadd_en    (fadd_en),
        .fadd_s     (fadd_s),
        .res_s      (res_s),
        .res0_valid (res0_valid),
        .res0_ready (res0_ready),
        .res1_valid (res1_valid),
        .res1_ready (res1_ready),
        .inflight   (inflight)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-precision helpers via double arithmetic (normal numbers, truncating).
    function automatic real s2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'({3'b000, x[30:23]} + 11'd896), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        if (e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
        real ra, rb;
        ra = s2r(a);
        rb = s2r(b);
        return r2s(sub ? ra - rb : ra + rb);
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        e = 8'($urandom_range(134, 120));
        return {1'($urandom_range(1, 0)), e, 23'($urandom)};
    endfunction

    // Adder stub: LAT enabled stages.
    logic [31:0] st [LAT];
    always @(posedge clk) begin
        if (fadd_en) begin
            st[0] <= fp_add(fadd_a, fadd_b, fadd_sub);
            for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
        end
    end
    assign fadd_s = st[LAT-1];

    // Reference model: queue of ops in issue order, each with the number of
    // enabled edges it has advanced since capture; it is at the head at age LAT-1.
    typedef struct packed {
        logic        tag;
        logic [31:0] data;
        logic [3:0]  age;
    } op_t;

    op_t         sb[$];
    logic        mprio = 1'b0;
    logic [31:0] last0 = 32'd0;
    logic [31:0] last1 = 32'd0;

    always @(negedge clk) begin
        logic head, htag, exp_stall, g, e0, e1;
        op_t  tmp;
        if (!clrn) begin
            check("rst_res0_valid", 32'(res0_valid), 32'd0);
            check("rst_res1_valid", 32'(res1_valid), 32'd0);
            check("rst_req0_ready", 32'(req0_ready), 32'd0);
            check("rst_req1_ready", 32'(req1_ready), 32'd0);
            check("rst_inflight", 32'(inflight), 32'd0);
            sb.delete();
            mprio = 1'b0;
        end else begin
            head      = (sb.size() > 0) && (sb[0].age == 4'(LAT - 1));
            htag      = head ? sb[0].tag : 1'b0;
            exp_stall = head && !(htag ? res1_ready : res0_ready);
            check("res0_valid", 32'(res0_valid), 32'(head && !htag));
            check("res1_valid", 32'(res1_valid), 32'(head && htag));
            check("fadd_en", 32'(fadd_en), 32'(!exp_stall));
            check("inflight", 32'(inflight), 32'(sb.size()));

            g  = (req0_valid && req1_valid) ? mprio : req1_valid;
            e0 = !exp_stall && req0_valid && !g;
            e1 = !exp_stall && req1_valid && g;
            check("req0_ready", 32'(req0_ready), 32'(e0));
            check("req1_ready", 32'(req1_ready), 32'(e1));
            if (req0_valid || req1_valid) begin
                check("fadd_a", fadd_a, g ? req1_a : req0_a);
                check("fadd_b", fadd_b, g ? req1_b : req0_b);
                check("fadd_sub", 32'(fadd_sub), 32'(g ? req1_sub : req0_sub));
            end else begin
                check("fadd_a_idle", fadd_a, 32'd0);
            end

            // Result consumption as presented by the DUT.
            if ((res0_valid && res0_ready) || (res1_valid && res1_ready)) begin
                if (!head) begin
                    check("spurious_result", 32'(res1_valid), 32'hDEAD);
                end else begin
                    check("res_tag", 32'(res1_valid), 32'(sb[0].tag));
                    check("res_data", res_s, sb[0].data);
                    if (res1_valid) last1 = res_s;
                    else            last0 = res_s;
                end
            end

            // Advance the model across the coming edge.
            if (!exp_stall) begin
                if (head) void'(sb.pop_front());
                for (int i = 0; i < sb.size(); i++) begin
                    tmp     = sb[i];
                    tmp.age = tmp.age + 4'd1;
                    sb[i]   = tmp;
                end
                if (e0 || e1) begin
                    tmp.tag  = g;
                    tmp.data = g ? fp_add(req1_a, req1_b, req1_sub)
                                 : fp_add(req0_a, req0_b, req0_sub);
                    tmp.age  = 4'd0;
                    sb.push_back(tmp);
                    mprio = ~g;
                end
            end
        end
    end

    // Per-cycle requester driver: holds operands until accepted; p*/r* in percent.
    task automatic drive(input int n, input int p0, input int p1, input int r0, input int r1);
        logic acc0, acc1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
            @(posedge clk);
            #1;
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(99, 0) < p0);
                req0_a     = rnd_fp();
                req0_b     = rnd_fp();
                req0_sub   = 1'($urandom_range(1, 0));
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(99, 0) < p1);
                req1_a     = rnd_fp();
                req1_b     = rnd_fp();
                req1_sub   = 1'($urandom_range(1, 0));
            end
            res0_ready = ($urandom_range(99, 0) < r0);
            res1_ready = ($urandom_range(99, 0) < r1);
        end
    endtask

    initial begin
        int lat_seen;
        clrn       = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        res0_ready = 1'b0; res1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 clrn = 1'b1;

        // Single op on port 0.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_sub = 1'b0;
        res0_ready = 1'b1; res1_ready = 1'b1;
        @(negedge clk);
        check("single_issue_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        lat_seen = 0;
        for (int k = 1; k <= int'(LAT) + 3; k++) begin
            @(negedge clk);
            if (res0_valid && lat_seen == 0) lat_seen = k;
        end
        #1;
        check("single_latency", 32'(lat_seen), 32'(LAT));
        check("single_result", last0, 32'h40400000);
        check("single_drain", 32'(inflight), 32'd0);

        // Contention: both always valid.
        drive(24, 100, 100, 100, 100);
        drive(LAT + 2, 0, 0, 100, 100);

        // Backpressure: port 1 result held at the head.
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h40A00000; req1_b = 32'h3F800000; req1_sub = 1'b1;
        res0_ready = 1'b1; res1_ready = 1'b0;
        drive(LAT + 5, 100, 0, 100, 0);
        @(negedge clk);
        check("bp_fadd_en", 32'(fadd_en), 32'd0);
        check("bp_req0_ready", 32'(req0_ready), 32'd0);
        check("bp_head", 32'(res1_valid), 32'd1);
        check("bp_data", res_s, 32'h40800000);
        check("bp_inflight", 32'(inflight), 32'(LAT));
        @(posedge clk); #1;
        res1_ready = 1'b1;
        drive(LAT + 4, 0, 0, 100, 100);
        check("bp_result", last1, 32'h40800000);

        // Bubbles: port 0 on alternate cycles.
        for (int k = 0; k < 8; k++) begin
            drive(1, 100, 0, 100, 100);
            drive(1, 0, 0, 100, 100);
        end

        // Reset with the pipeline full.
        drive(LAT + 2, 100, 100, 100, 100);
        @(negedge clk);
        check("pre_rst_inflight", 32'(inflight), 32'(LAT));
        @(posedge clk); #2;
        clrn = 1'b0;
        #1;
        check("rst_now_res0", 32'(res0_valid), 32'd0);
        check("rst_now_res1", 32'(res1_valid), 32'd0);
        check("rst_now_rdy0", 32'(req0_ready), 32'd0);
        check("rst_now_rdy1", 32'(req1_ready), 32'd0);
        check("rst_now_inflight", 32'(inflight), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        clrn  = 1'b1;
        last0 = 32'd0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'h3FC00000; req0_b = 32'h3F000000; req0_sub = 1'b0;
        res0_ready = 1'b1; res1_ready = 1'b1;
        drive(LAT + 3, 0, 0, 100, 100);
        check("post_rst_result", last0, 32'h40000000);

        // Port 1 streaming alone.
        drive(20, 0, 100, 100, 100);

        // Random phases.
        for (int ph = 0; ph < 6; ph++) begin
            drive(80, $urandom_range(100, 20), $urandom_range(100, 20),
                  $urandom_range(100, 30), $urandom_range(100, 30));
        end
        drive(LAT + 10, 0, 0, 100, 100);
        @(negedge clk);
        check("final_inflight", 32'(inflight), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
